// File: rtl/pb_job_dispatcher.sv
// Job FIFO feeding NUM_CH packet-builder channels round-robin. Tracks each channel through
// start/busy/irq, flags channels that never go busy, and merges completions into one irq.
module pb_job_dispatcher #(
  parameter  int NUM_CH  = 2,
  parameter  int DEPTH   = 4,
  parameter  int ADDR_W  = 32,
  parameter  int TIMEOUT = 15,
  localparam int DW      = 2*ADDR_W+17,
  localparam int CW      = $clog2(DEPTH)+1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [DW-1:0]        job_desc,
  output logic [NUM_CH-1:0]    ch_start,
  output logic [NUM_CH*DW-1:0] ch_desc,
  input  logic [NUM_CH-1:0]    ch_busy,
  input  logic [NUM_CH-1:0]    ch_irq,
  output logic [NUM_CH-1:0]    irq_status,
  output logic [NUM_CH-1:0]    err_status,
  input  logic [NUM_CH-1:0]    irq_mask,
  input  logic [NUM_CH-1:0]    irq_clr,
  output logic                 irq,
  output logic [CW-1:0]        fifo_count,
  output logic                 idle
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] TMO_W = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RUN} state_t;

  logic [DW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, fifo_nempty;
  logic [NUM_CH-1:0] ch_idle, dispatch, done_evt, err_evt;
  logic [NUM_CH-1:0] irq_st_nxt, err_st_nxt;
  logic [CH_W-1:0]   last_gnt, gnt_idx;
  logic              gnt_vld;
  int                rr_c;

  // ---------------- job FIFO (no bypass: a fresh push dispatches one edge later)
  assign job_ready   = fifo_count < CW'(DEPTH);
  assign push        = job_valid & job_ready;
  assign fifo_nempty = fifo_count != '0;
  assign pop         = fifo_nempty & (|ch_idle);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= job_desc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- round-robin: first idle channel after the last grant, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_gnt;
    rr_c    = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_c = (int'(last_gnt) + k) % NUM_CH;
      if (!gnt_vld && ch_idle[CH_W'(rr_c)]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(rr_c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last_gnt <= CH_W'(NUM_CH-1);
    else if (pop && gnt_vld)   last_gnt <= gnt_idx;
  end

  // ---------------- per-channel launch / wait-busy / run tracking
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t        state, state_nxt;
    logic [7:0]    wait_cnt;
    logic [DW-1:0] desc_q;
    logic          tmo;

    assign dispatch[i] = pop & (gnt_idx == CH_W'(i));
    // Fires on the TIMEOUT-th busy-less WAIT cycle.
    assign tmo = (wait_cnt + 8'd1) == TMO_W;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                            wait_cnt <= '0;
      else if (state == S_LAUNCH)                            wait_cnt <= '0;
      else if (state == S_WAIT && !ch_busy[i] && !ch_irq[i]) wait_cnt <= wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           desc_q <= '0;
      else if (dispatch[i]) desc_q <= mem[rd_ptr];
    end

    always_comb begin
      state_nxt = state;
      case (state)
        S_IDLE:   if (dispatch[i]) state_nxt = S_LAUNCH;
        S_LAUNCH: state_nxt = S_WAIT;
        S_WAIT: begin
          if (ch_irq[i])       state_nxt = S_IDLE;
          else if (ch_busy[i]) state_nxt = S_RUN;
          else if (tmo)        state_nxt = S_IDLE;
        end
        S_RUN:    if (ch_irq[i]) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end

    // A fast channel may complete while still in WAIT; that wins over busy/timeout.
    always_comb begin
      ch_idle[i]  = (state == S_IDLE);
      ch_start[i] = (state == S_LAUNCH);
      done_evt[i] = ((state == S_WAIT) || (state == S_RUN)) && ch_irq[i];
      err_evt[i]  = (state == S_WAIT) && !ch_irq[i] && !ch_busy[i] && tmo;
    end

    assign ch_desc[i*DW +: DW] = desc_q;
  end

  // ---------------- sticky status, set wins over a coincident clear
  assign irq_st_nxt = (irq_status & ~irq_clr) | done_evt;
  assign err_st_nxt = (err_status & ~irq_clr) | err_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status <= '0;
      err_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= irq_st_nxt;
      err_status <= err_st_nxt;
      irq        <= (|(irq_st_nxt & irq_mask)) | (|err_st_nxt);
    end
  end

  assign idle = !fifo_nempty && (&ch_idle);

endmodule

// File: tb/tb_pb_job_dispatcher.sv
// Bench for pb_job_dispatcher: directed scenarios with literal expectations plus randomized
// traffic, all cross-checked each cycle against a queue-based behavioural model.
module tb_pb_job_dispatcher;
  localparam int NUM_CH  = 2;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int DW      = 2*ADDR_W+17;
  localparam int CW      = $clog2(DEPTH)+1;

  logic                 clk = 1'b0, rst_n = 1'b0;
  logic                 job_valid = 1'b0, job_ready, irq, idle;
  logic [DW-1:0]        job_desc = '0;
  logic [NUM_CH-1:0]    ch_start, irq_status, err_status;
  logic [NUM_CH-1:0]    ch_busy = '0, ch_irq = '0, irq_mask = '0, irq_clr = '0;
  logic [NUM_CH*DW-1:0] ch_desc;
  logic [CW-1:0]        fifo_count;

  pb_job_dispatcher #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready), .job_desc(job_desc),
    .ch_start(ch_start), .ch_desc(ch_desc), .ch_busy(ch_busy), .ch_irq(ch_irq),
    .irq_status(irq_status), .err_status(err_status), .irq_mask(irq_mask), .irq_clr(irq_clr),
    .irq(irq), .fifo_count(fifo_count), .idle(idle));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: job queue + per-channel phase and wait start time
  // phase: 0 idle, 1 start pulse, 2 waiting for busy, 3 running
  logic [DW-1:0]     mq[$];
  int                ph[NUM_CH];
  int                wstart[NUM_CH];
  logic [DW-1:0]     mdesc[NUM_CH];
  logic [NUM_CH-1:0] mist, mest, dn, to;
  logic              mirq;
  int                mlast, edge_no, pc, cc;
  bit                acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      for (int c = 0; c < NUM_CH; c++) begin ph[c] = 0; wstart[c] = 0; mdesc[c] = '0; end
      mist = '0; mest = '0; mirq = 1'b0; mlast = NUM_CH-1; edge_no = 0;
    end else begin
      edge_no++;
      acc = job_valid && (mq.size() < DEPTH);
      pc = -1;
      if (mq.size() > 0)
        for (int k = 1; k <= NUM_CH; k++) begin
          cc = (mlast + k) % NUM_CH;
          if (pc < 0 && ph[cc] == 0) pc = cc;
        end
      dn = '0; to = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        case (ph[c])
          0: if (c == pc) begin ph[c] = 1; mdesc[c] = mq.pop_front(); mlast = c; end
          1: begin ph[c] = 2; wstart[c] = edge_no; end
          2: if (ch_irq[c]) begin ph[c] = 0; dn[c] = 1'b1; end
             else if (ch_busy[c]) ph[c] = 3;
             else if (edge_no - wstart[c] == TIMEOUT) begin ph[c] = 0; to[c] = 1'b1; end
          default: if (ch_irq[c]) begin ph[c] = 0; dn[c] = 1'b1; end
        endcase
      end
      if (acc) mq.push_back(job_desc);
      mist = (mist & ~irq_clr) | dn;
      mest = (mest & ~irq_clr) | to;
      mirq = (|(mist & irq_mask)) | (|mest);
    end
  end

  // ---------------- per-cycle comparison against the model
  logic [NUM_CH*DW-1:0] e_desc;
  logic [NUM_CH-1:0]    e_start;
  bit                   e_all;

  always @(negedge clk) begin
    if (rst_n) begin
      e_desc = '0; e_start = '0; e_all = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        e_desc[c*DW +: DW] = mdesc[c];
        e_start[c] = (ph[c] == 1);
        if (ph[c] != 0) e_all = 1'b0;
      end
      chk("m_job_ready",  256'(job_ready),  256'(mq.size() < DEPTH));
      chk("m_fifo_count", 256'(fifo_count), 256'(mq.size()));
      chk("m_ch_start",   256'(ch_start),   256'(e_start));
      chk("m_ch_desc",    256'(ch_desc),    256'(e_desc));
      chk("m_irq_status", 256'(irq_status), 256'(mist));
      chk("m_err_status", 256'(err_status), 256'(mest));
      chk("m_irq",        256'(irq),        256'(mirq));
      chk("m_idle",       256'(idle),       256'(e_all && mq.size() == 0));
    end
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rdesc();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic wait_start(input int c);
    for (int i = 0; i < 40 && !ch_start[c]; i++) step();
    chk("wait_start", 256'(ch_start[c]), 256'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && !idle; i++) step();
    chk("wait_idle", 256'(idle), 256'(1));
  endtask

  logic [DW-1:0] d0, jobs[7];
  int order[$];
  int pb, pi;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) step();
    chk("rst_job_ready",  256'(job_ready),  256'(1));
    chk("rst_idle",       256'(idle),       256'(1));
    chk("rst_fifo_count", 256'(fifo_count), 256'(0));
    chk("rst_ch_desc",    256'(ch_desc),    256'(0));
    chk("rst_irq",        256'(irq),        256'(0));
    rst_n = 1'b1;

    // single job: push at edge 0, start pulse in cycle 2 only
    d0 = rdesc();
    job_valid = 1'b1; job_desc = d0;
    step();
    job_valid = 1'b0;
    chk("t1_cnt_c1",   256'(fifo_count), 256'(1));
    chk("t1_start_c1", 256'(ch_start),   256'(0));
    step();
    chk("t1_start_c2", 256'(ch_start),   256'(2'b01));
    chk("t1_desc0",    256'(ch_desc[0 +: DW]), 256'(d0));
    ch_busy = 2'b01;
    step();
    chk("t1_start_c3", 256'(ch_start),   256'(0));
    ch_irq = 2'b01; irq_mask = 2'b01;
    step();
    ch_irq = '0; ch_busy = '0;
    step();
    chk("t1_irq_status", 256'(irq_status), 256'(2'b01));
    chk("t1_irq",        256'(irq),        256'(1));
    chk("t1_idle",       256'(idle),       256'(1));
    irq_clr = 2'b01;
    step();
    irq_clr = '0;
    chk("t1_clr", 256'(irq_status), 256'(0));

    // fill the FIFO while both channels run
    ch_busy = 2'b11;
    for (int k = 0; k < 7; k++) jobs[k] = rdesc();
    for (int k = 0; k < 6; k++) begin job_valid = 1'b1; job_desc = jobs[k]; step(); end
    chk("t2_ready_full", 256'(job_ready),  256'(0));
    chk("t2_cnt_full",   256'(fifo_count), 256'(4));
    job_desc = jobs[6];
    step();
    job_valid = 1'b0;
    chk("t2_no_push", 256'(fifo_count), 256'(4));
    ch_irq = 2'b10;
    step();
    ch_irq = '0;
    step();
    chk("t2_cnt3",   256'(fifo_count),        256'(3));
    chk("t2_start1", 256'(ch_start),          256'(2'b10));
    chk("t2_desc1",  256'(ch_desc[DW +: DW]), 256'(jobs[2]));
    ch_busy = '0; ch_irq = 2'b11;
    wait_idle();
    ch_irq = '0; irq_clr = 2'b11;
    step();
    irq_clr = '0;

    // reset mid-job: two jobs queued, channels running
    ch_busy = 2'b11;
    for (int k = 0; k < 4; k++) begin job_valid = 1'b1; job_desc = rdesc(); step(); end
    job_valid = 1'b0;
    step(); step();
    chk("t6_pre_cnt", 256'(fifo_count), 256'(2));
    rst_n = 1'b0;
    #1;
    chk("t6_cnt",   256'(fifo_count), 256'(0));
    chk("t6_idle",  256'(idle),       256'(1));
    chk("t6_start", 256'(ch_start),   256'(0));
    chk("t6_ready", 256'(job_ready),  256'(1));
    chk("t6_irq",   256'(irq),        256'(0));
    step();
    rst_n = 1'b1; ch_busy = '0;
    d0 = rdesc();
    job_valid = 1'b1; job_desc = d0;
    step();
    job_valid = 1'b0;
    step();
    chk("t6_restart", 256'(ch_start),         256'(2'b01));
    chk("t6_desc0",   256'(ch_desc[0 +: DW]), 256'(d0));
    step();
    ch_irq = 2'b01;
    step();
    ch_irq = '0;
    chk("t6_done", 256'(irq_status), 256'(2'b01));

    // round-robin with immediately completing channels, pointer freshly reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ch_irq = 2'b11;
    for (int i = 0; i < 24; i++) begin
      job_valid = (i < 4); job_desc = rdesc();
      step();
      for (int c = 0; c < NUM_CH; c++) if (ch_start[c]) order.push_back(c);
    end
    job_valid = 1'b0; ch_irq = '0;
    chk("t3_n_starts", 256'(order.size()), 256'(4));
    for (int k = 0; k < 4 && k < order.size(); k++) chk("t3_order", 256'(order[k]), 256'(k % 2));

    // timeout: busy never comes, mask off
    irq_mask = '0; irq_clr = 2'b11;
    step();
    irq_clr = '0;
    job_valid = 1'b1; job_desc = rdesc();
    step();
    job_valid = 1'b0;
    wait_start(0);
    for (int i = 0; i < TIMEOUT; i++) step();
    chk("t4_err_early", 256'(err_status), 256'(0));
    step();
    chk("t4_err",  256'(err_status), 256'(2'b01));
    chk("t4_irq",  256'(irq),        256'(1));
    chk("t4_idle", 256'(idle),       256'(1));
    chk("t4_no_irqst", 256'(irq_status), 256'(0));
    irq_clr = 2'b11;
    step();
    irq_clr = '0;

    // clear coincident with a new completion: set wins
    irq_mask = 2'b01; ch_irq = 2'b10;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 2; k++) begin job_valid = 1'b1; job_desc = rdesc(); step(); end
      job_valid = 1'b0;
      wait_start(0);
      step();
      ch_irq = 2'b11;
      if (r == 1) irq_clr = 2'b01;
      step();
      ch_irq = 2'b10; irq_clr = '0;
      chk("t5_set", 256'(irq_status[0]), 256'(1));
    end
    ch_irq = '0; irq_clr = 2'b01;
    step();
    irq_clr = '0;
    chk("t5_clr", 256'(irq_status[0]), 256'(0));

    // randomized traffic, model-checked every cycle
    for (int phs = 0; phs < 3; phs++) begin
      pb = (phs == 0) ? 40 : (phs == 1) ? 0 : 85;
      pi = (phs == 0) ? 20 : (phs == 1) ? 0 : 8;
      for (int i = 0; i < 1000; i++) begin
        job_valid = ($urandom_range(0, 99) < 50);
        job_desc  = rdesc();
        for (int c = 0; c < NUM_CH; c++) begin
          ch_busy[c] = ($urandom_range(0, 99) < pb);
          ch_irq[c]  = ($urandom_range(0, 99) < pi);
          irq_clr[c] = ($urandom_range(0, 99) < 5);
        end
        if ($urandom_range(0, 31) == 0) irq_mask = NUM_CH'($urandom());
        step();
      end
    end
    job_valid = 1'b0; ch_busy = '0; ch_irq = '0; irq_clr = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
